// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// Build option: UART_RX_CTRL_TIMEOUT_EN (see uart_rx_ctrl.sv).
package uart_rx_pkg;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_PAR  = 2'b01;
  localparam logic [1:0] ERR_STOP = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  localparam int MIN_PRESCALE = 5;
  localparam int FRAME_CNT_W  = 9;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] err;
  } rx_entry_t;

  // Frame length in clocks: start + 8 data + stop (+ parity) bits.
  function automatic logic [FRAME_CNT_W-1:0] frame_clks(input logic [4:0] prescale,
                                                        input logic       parity_en);
    logic [FRAME_CNT_W-1:0] bits;
    logic [FRAME_CNT_W-1:0] ps;
    bits = parity_en ? FRAME_CNT_W'(11) : FRAME_CNT_W'(10);
    ps   = {{(FRAME_CNT_W-5){1'b0}}, prescale};
    return bits * ps;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous FIFO of 10-bit {byte, status} entries; head read straight from storage registers.
// Handshake: push accepted when not full or when a pop happens the same cycle; pop ignored when empty.
module uart_rx_ctrl_fifo
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  rx_entry_t       push_data_i,
  input  logic            pop_i,
  output rx_entry_t       head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            drop_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  rx_entry_t   mem_q [FIFO_DEPTH];
  logic        do_push;
  logic        do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full_o  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Config/sequencing controller around the UART receiver: frame tracking, config shadow, byte FIFO, error stats.
// Build option: define UART_RX_CTRL_TIMEOUT_EN to push a {00,11} entry when a frame expires without a byte.
// Consumer handshake: an entry transfers on a cycle where out_valid and out_ready are both high.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int RESET_PRESCALE = 8
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       S_Data,
  input  logic [4:0] cfg_Prescale,
  input  logic       cfg_Parity_EN,
  input  logic       cfg_Parity_type,
  input  logic       cfg_load,
  output logic       cfg_pending,
  output logic       cfg_reject,
  output logic [4:0] rx_Prescale,
  output logic       rx_Parity_EN,
  output logic       rx_Parity_type,
  input  logic       rx_Data_valid,
  input  logic [7:0] rx_P_Data,
  input  logic       rx_Parity_error,
  input  logic       rx_stop_error,
  output logic [7:0] out_data,
  output logic [1:0] out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  input  logic       clear,
  output logic [7:0] err_count,
  output state_t     dbg_state_o
);

  logic s_meta_q, s_sync_q, s_prev_q;
  logic par_prev_q, stop_prev_q;
  logic s_fall, par_rise, stop_rise;

  state_t                 state_q, state_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic                   expiry;

  logic [4:0] sh_prescale_q, sh_prescale_d;
  logic       sh_par_en_q, sh_par_en_d;
  logic       sh_par_type_q, sh_par_type_d;
  logic       pending_q, pending_d;
  logic       reject_q, reject_d;
  logic [4:0] rx_prescale_q, rx_prescale_d;
  logic       rx_par_en_q, rx_par_en_d;
  logic       rx_par_type_q, rx_par_type_d;
  logic       cfg_ok, apply;

  logic       push;
  rx_entry_t  push_entry;
  logic       err_event;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       overrun_q, overrun_d;

  rx_entry_t  head;
  logic       fifo_full, fifo_empty, fifo_drop;

  assign s_fall    = s_prev_q & ~s_sync_q;
  assign par_rise  = rx_Parity_error & ~par_prev_q;
  assign stop_rise = rx_stop_error & ~stop_prev_q;
  assign expiry    = (state_q == BUSY) && (cnt_q == FRAME_CNT_W'(1));

  // Error edges outrank a good-byte pulse; parity outranks stop.
  always_comb begin
    push            = 1'b0;
    push_entry.data = rx_P_Data;
    push_entry.err  = ERR_OK;
    if (par_rise) begin
      push           = 1'b1;
      push_entry.err = ERR_PAR;
    end else if (stop_rise) begin
      push           = 1'b1;
      push_entry.err = ERR_STOP;
    end else if (rx_Data_valid) begin
      push           = 1'b1;
      push_entry.err = ERR_OK;
    end
`ifdef UART_RX_CTRL_TIMEOUT_EN
    else if (expiry) begin
      push            = 1'b1;
      push_entry.data = 8'h00;
      push_entry.err  = ERR_TMO;
    end
`endif
  end

  assign err_event = push && (push_entry.err != ERR_OK);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (s_fall) begin
          state_d = BUSY;
          cnt_d   = frame_clks(rx_prescale_q, rx_par_en_q);
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (push || expiry) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Config only reaches the receiver between frames; a start edge defers the apply.
  assign cfg_ok = cfg_load && (cfg_Prescale >= 5'(MIN_PRESCALE));
  assign apply  = pending_q && (state_q == IDLE) && !s_fall;

  always_comb begin
    sh_prescale_d = sh_prescale_q;
    sh_par_en_d   = sh_par_en_q;
    sh_par_type_d = sh_par_type_q;
    pending_d     = pending_q;
    rx_prescale_d = rx_prescale_q;
    rx_par_en_d   = rx_par_en_q;
    rx_par_type_d = rx_par_type_q;
    reject_d      = cfg_load && !cfg_ok;
    if (apply) begin
      rx_prescale_d = sh_prescale_q;
      rx_par_en_d   = sh_par_en_q;
      rx_par_type_d = sh_par_type_q;
      pending_d     = 1'b0;
    end
    if (cfg_ok) begin
      sh_prescale_d = cfg_Prescale;
      sh_par_en_d   = cfg_Parity_EN;
      sh_par_type_d = cfg_Parity_type;
      pending_d     = 1'b1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    overrun_d = overrun_q;
    if (clear) begin
      err_cnt_d = 8'd0;
      overrun_d = 1'b0;
    end else begin
      if (err_event && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
      if (fifo_drop) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s_meta_q      <= 1'b1;
      s_sync_q      <= 1'b1;
      s_prev_q      <= 1'b1;
      par_prev_q    <= 1'b0;
      stop_prev_q   <= 1'b0;
      state_q       <= IDLE;
      cnt_q         <= '0;
      sh_prescale_q <= 5'(RESET_PRESCALE);
      sh_par_en_q   <= 1'b0;
      sh_par_type_q <= 1'b0;
      pending_q     <= 1'b0;
      reject_q      <= 1'b0;
      rx_prescale_q <= 5'(RESET_PRESCALE);
      rx_par_en_q   <= 1'b0;
      rx_par_type_q <= 1'b0;
      err_cnt_q     <= 8'd0;
      overrun_q     <= 1'b0;
    end else begin
      s_meta_q      <= S_Data;
      s_sync_q      <= s_meta_q;
      s_prev_q      <= s_sync_q;
      par_prev_q    <= rx_Parity_error;
      stop_prev_q   <= rx_stop_error;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_prescale_q <= sh_prescale_d;
      sh_par_en_q   <= sh_par_en_d;
      sh_par_type_q <= sh_par_type_d;
      pending_q     <= pending_d;
      reject_q      <= reject_d;
      rx_prescale_q <= rx_prescale_d;
      rx_par_en_q   <= rx_par_en_d;
      rx_par_type_q <= rx_par_type_d;
      err_cnt_q     <= err_cnt_d;
      overrun_q     <= overrun_d;
    end
  end

  uart_rx_ctrl_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_i      (Reset),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (out_ready),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .drop_o     (fifo_drop)
  );

  assign cfg_pending    = pending_q;
  assign cfg_reject     = reject_q;
  assign rx_Prescale    = rx_prescale_q;
  assign rx_Parity_EN   = rx_par_en_q;
  assign rx_Parity_type = rx_par_type_q;
  assign out_data       = head.data;
  assign out_err        = head.err;
  assign out_valid      = ~fifo_empty;
  assign overrun        = overrun_q;
  assign err_count      = err_cnt_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: config shadowing, FIFO handshake, error priority/saturation, frame expiry.
module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       S_Data;
  logic [4:0] cfg_Prescale;
  logic       cfg_Parity_EN;
  logic       cfg_Parity_type;
  logic       cfg_load;
  logic       cfg_pending;
  logic       cfg_reject;
  logic [4:0] rx_Prescale;
  logic       rx_Parity_EN;
  logic       rx_Parity_type;
  logic       rx_Data_valid;
  logic [7:0] rx_P_Data;
  logic       rx_Parity_error;
  logic       rx_stop_error;
  logic [7:0] out_data;
  logic [1:0] out_err;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       clear;
  logic [7:0] err_count;
  state_t     dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  uart_rx_ctrl #(.FIFO_DEPTH(4), .RESET_PRESCALE(8)) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .S_Data         (S_Data),
    .cfg_Prescale   (cfg_Prescale),
    .cfg_Parity_EN  (cfg_Parity_EN),
    .cfg_Parity_type(cfg_Parity_type),
    .cfg_load       (cfg_load),
    .cfg_pending    (cfg_pending),
    .cfg_reject     (cfg_reject),
    .rx_Prescale    (rx_Prescale),
    .rx_Parity_EN   (rx_Parity_EN),
    .rx_Parity_type (rx_Parity_type),
    .rx_Data_valid  (rx_Data_valid),
    .rx_P_Data      (rx_P_Data),
    .rx_Parity_error(rx_Parity_error),
    .rx_stop_error  (rx_stop_error),
    .out_data       (out_data),
    .out_err        (out_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overrun        (overrun),
    .clear          (clear),
    .err_count      (err_count),
    .dbg_state_o    (dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: head must match the oldest expected entry, then pop it.
  task automatic pop_check(input string tag);
    logic [9:0] exp_v;
    exp_v = exp_q.pop_front();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_entry"}, {22'd0, out_data, out_err}, {22'd0, exp_v});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Driver: start bit, receiver result pulse (optionally with a same-cycle pop), idle gap.
  task automatic frame(input logic [7:0] d, input logic dv, input logic par,
                       input logic stp, input logic pop);
    S_Data = 1'b0;
    repeat (3) tick();
    chk("frame_busy", {31'd0, dbg_state}, {31'd0, BUSY});
    S_Data          = 1'b1;
    rx_P_Data       = d;
    rx_Data_valid   = dv;
    rx_Parity_error = par;
    rx_stop_error   = stp;
    out_ready       = pop;
    tick();
    rx_Data_valid   = 1'b0;
    rx_Parity_error = 1'b0;
    rx_stop_error   = 1'b0;
    out_ready       = 1'b0;
    chk("frame_idle", {31'd0, dbg_state}, {31'd0, IDLE});
    tick();
  endtask

  task automatic load_cfg(input logic [4:0] ps);
    cfg_Prescale = ps;
    cfg_load     = 1'b1;
    tick();
    cfg_load     = 1'b0;
  endtask

  initial begin
    int n;
    Reset = 1'b1; S_Data = 1'b1; cfg_Prescale = 5'd0; cfg_Parity_EN = 1'b0;
    cfg_Parity_type = 1'b0; cfg_load = 1'b0; rx_Data_valid = 1'b0; rx_P_Data = 8'h00;
    rx_Parity_error = 1'b0; rx_stop_error = 1'b0; out_ready = 1'b0; clear = 1'b0;
    repeat (2) tick();
    Reset = 1'b0;
    tick();

    // Reset state
    chk("rst_prescale", {27'd0, rx_Prescale}, 32'd8);
    chk("rst_par_en", {31'd0, rx_Parity_EN}, 32'd0);
    chk("rst_par_type", {31'd0, rx_Parity_type}, 32'd0);
    chk("rst_pending", {31'd0, cfg_pending}, 32'd0);
    chk("rst_reject", {31'd0, cfg_reject}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {22'd0, out_data, out_err}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_errcnt", {24'd0, err_count}, 32'd0);
    chk("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});

    // 1: config apply while IDLE
    load_cfg(5'd16);
    chk("t1_pending", {31'd0, cfg_pending}, 32'd1);
    chk("t1_ps_hold", {27'd0, rx_Prescale}, 32'd8);
    tick();
    chk("t1_ps_new", {27'd0, rx_Prescale}, 32'd16);
    chk("t1_pending_clr", {31'd0, cfg_pending}, 32'd0);
    load_cfg(5'd8);
    tick();
    chk("t1_ps_back", {27'd0, rx_Prescale}, 32'd8);

    // 2: good byte through the FIFO
    frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({8'h5A, 2'b00});
    pop_check("t2_pop");
    chk("t2_empty", {31'd0, out_valid}, 32'd0);

    // 3: config held during BUSY, reject of low prescale
    S_Data = 1'b0;
    repeat (3) tick();
    chk("t3_busy", {31'd0, dbg_state}, {31'd0, BUSY});
    S_Data = 1'b1;
    load_cfg(5'd12);
    chk("t3_pending", {31'd0, cfg_pending}, 32'd1);
    chk("t3_ps_busy0", {27'd0, rx_Prescale}, 32'd8);
    tick();
    chk("t3_ps_busy1", {27'd0, rx_Prescale}, 32'd8);
    rx_P_Data = 8'h11; rx_Data_valid = 1'b1;
    tick();
    rx_Data_valid = 1'b0;
    exp_q.push_back({8'h11, 2'b00});
    chk("t3_idle", {31'd0, dbg_state}, {31'd0, IDLE});
    chk("t3_ps_end", {27'd0, rx_Prescale}, 32'd8);
    tick();
    chk("t3_ps_applied", {27'd0, rx_Prescale}, 32'd12);
    chk("t3_pending_clr", {31'd0, cfg_pending}, 32'd0);
    load_cfg(5'd3);
    chk("t3_reject", {31'd0, cfg_reject}, 32'd1);
    chk("t3_rej_pending", {31'd0, cfg_pending}, 32'd0);
    tick();
    chk("t3_reject_pulse", {31'd0, cfg_reject}, 32'd0);
    chk("t3_ps_kept", {27'd0, rx_Prescale}, 32'd12);
    load_cfg(5'd8);
    tick();
    chk("t3_ps_back", {27'd0, rx_Prescale}, 32'd8);
    pop_check("t3_pop");

    // 4: overrun on full FIFO, then full push+pop
    frame(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'hA2, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
    frame(8'hA4, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_no_overrun", {31'd0, overrun}, 32'd0);
    frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_q.push_back({8'hA1, 2'b00});
    exp_q.push_back({8'hA2, 2'b00});
    exp_q.push_back({8'hA3, 2'b00});
    exp_q.push_back({8'hA4, 2'b00});
    chk("t4_overrun", {31'd0, overrun}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4_clear", {31'd0, overrun}, 32'd0);
    chk("t4_head", {22'd0, out_data, out_err}, {22'd0, exp_q[0]});
    frame(8'hA6, 1'b1, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back({8'hA6, 2'b00});
    chk("t4_pushpop_ovr", {31'd0, overrun}, 32'd0);
    for (int i = 0; i < 4; i++) pop_check("t4_drain");
    chk("t4_empty", {31'd0, out_valid}, 32'd0);

    // 5: error priority, saturation, clear priority
    frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    exp_q.push_back({8'h3C, 2'b01});
    chk("t5_errcnt1", {24'd0, err_count}, 32'd1);
    pop_check("t5_par_entry");
    rx_P_Data = 8'h77;
    for (int i = 0; i < 253; i++) begin
      rx_stop_error = 1'b1;
      tick();
      rx_stop_error = 1'b0;
      tick();
      if (i < 4) exp_q.push_back({8'h77, 2'b10});
    end
    chk("t5_errcnt254", {24'd0, err_count}, 32'd254);
    for (int i = 0; i < 2; i++) begin
      rx_stop_error = 1'b1;
      tick();
      rx_stop_error = 1'b0;
      tick();
    end
    chk("t5_errcnt_sat", {24'd0, err_count}, 32'd255);
    chk("t5_overrun", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 4; i++) pop_check("t5_drain");
    chk("t5_empty", {31'd0, out_valid}, 32'd0);
    clear = 1'b1; rx_stop_error = 1'b1;
    tick();
    clear = 1'b0; rx_stop_error = 1'b0;
    exp_q.push_back({8'h77, 2'b10});
    chk("t5_clear_cnt", {24'd0, err_count}, 32'd0);
    chk("t5_clear_ovr", {31'd0, overrun}, 32'd0);
    pop_check("t5_clear_entry");

    // 6: glitch start bit with no receiver result -> expiry after 10*8 clocks
    S_Data = 1'b0;
    tick();
    S_Data = 1'b1;
    n = 0;
    while (dbg_state != BUSY && n < 10) begin
      tick();
      n++;
    end
    chk("t6_entered_busy", {31'd0, dbg_state}, {31'd0, BUSY});
    n = 0;
    while (dbg_state == BUSY && n < 200) begin
      tick();
      n++;
    end
    chk("t6_busy_len", n, 32'd80);
    chk("t6_idle", {31'd0, dbg_state}, {31'd0, IDLE});
`ifdef UART_RX_CTRL_TIMEOUT_EN
    exp_q.push_back({8'h00, 2'b11});
    chk("t6_tmo_errcnt", {24'd0, err_count}, 32'd1);
    pop_check("t6_tmo_entry");
`else
    chk("t6_no_entry", {31'd0, out_valid}, 32'd0);
    chk("t6_errcnt", {24'd0, err_count}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
